// File: rtl/obi_resp_pkg.sv
// Shared types and parameter limits for the OBI memory responder and its response queue.
package obi_resp_pkg;

    localparam int MAX_PND_MIN  = 1;
    localparam int MAX_PND_MAX  = 4;
    localparam int RESP_LAT_MIN = 1;
    localparam int RESP_LAT_MAX = 8;

    // Wide enough to hold the largest legal latency as a saturated age.
    localparam int AGE_W = $clog2(RESP_LAT_MAX + 1);

    typedef struct packed {
        logic [31:0]      data;
        logic [AGE_W-1:0] age;
    } resp_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response queue; every occupied slot carries an age that counts cycles since push.
module obi_resp_fifo
    import obi_resp_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int RESP_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output resp_entry_t head_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_SAT   = AGE_W'(RESP_LAT);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0][AGE_W-1:0] age_all;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Age 0 marks a free slot; a push starts at 1 so the count equals cycles since acceptance.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [AGE_W-1:0] age_q, age_d;

        always_comb begin
            age_d = age_q;
            if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                age_d = AGE_W'(1);
            end else if (do_pop && (rd_ptr_q == PTR_W'(gi))) begin
                age_d = '0;
            end else if ((age_q != '0) && (age_q != AGE_SAT)) begin
                age_d = age_q + AGE_W'(1);
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                age_q <= '0;
            end else begin
                age_q <= age_d;
            end
        end

        assign age_all[gi] = age_q;
    end

    assign head_o.data = data_q[rd_ptr_q];
    assign head_o.age  = age_all[rd_ptr_q];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory target: byte-lane memory, credit-limited grant and fixed-minimum-latency in-order responses.
module obi_mem_responder
    import obi_resp_pkg::*;
#(
    parameter int ADDR_WORDS = 256,
    parameter int MAX_PND    = 2,
    parameter int RESP_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        stall_i
);

    localparam int IDX_W = $clog2(ADDR_WORDS);
    localparam int CNT_W = $clog2(MAX_PND + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PND);
    localparam logic [AGE_W-1:0] LAT_AGE = AGE_W'(RESP_LAT);

    logic [CNT_W-1:0] pnd_cnt_q, pnd_cnt_d;
    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [31:0]      push_data;
    logic             fifo_empty;
    logic             fifo_full_unused;
    logic             unused_addr_bits;
    resp_entry_t      head;

    assign word_idx         = addr_i[2 +: IDX_W];
    assign unused_addr_bits = ^{addr_i[31:2+IDX_W], addr_i[1:0]};

    // A credit freed by this cycle's response is only usable from the next cycle on.
    assign gnt_o  = req_i && !stall_i && (pnd_cnt_q < MAX_CNT);
    assign accept = req_i && gnt_o;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q [ADDR_WORDS];

        always_ff @(posedge clock) begin
            if (accept && we_i && be_i[gi]) begin
                lane_q[word_idx] <= wdata_i[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = lane_q[word_idx];
    end

    // Read data is captured into the queue at acceptance, so later writes cannot leak in.
    assign push_data = we_i ? 32'h0 : rd_word;

    obi_resp_fifo #(
        .DEPTH    (MAX_PND),
        .RESP_LAT (RESP_LAT)
    ) u_resp_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (accept),
        .push_data_i (push_data),
        .pop_i       (rvalid_o),
        .full_o      (fifo_full_unused),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign rvalid_o = !fifo_empty && (pnd_cnt_q != '0) && (head.age >= LAT_AGE);
    assign rdata_o  = rvalid_o ? head.data : 32'h0;

    always_comb begin
        case ({accept, rvalid_o})
            2'b10:   pnd_cnt_d = pnd_cnt_q + CNT_W'(1);
            2'b01:   pnd_cnt_d = pnd_cnt_q - CNT_W'(1);
            default: pnd_cnt_d = pnd_cnt_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pnd_cnt_q <= '0;
        end else begin
            pnd_cnt_q <= pnd_cnt_d;
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: table of transactions with a response scoreboard plus cycle-exact corner sequences.
module tb_obi_mem_responder;

    localparam int LAT_A = 3;
    localparam int LAT_B = 4;
    localparam int PND   = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_a, req_b, stall_a, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [31:0] rdata_a, rdata_b;

    always #5 clock = ~clock;

    obi_mem_responder #(.ADDR_WORDS(256), .MAX_PND(PND), .RESP_LAT(LAT_A)) dut_a (
        .clock(clock), .reset(reset), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
        .stall_i(stall_a)
    );

    obi_mem_responder #(.ADDR_WORDS(256), .MAX_PND(PND), .RESP_LAT(LAT_B)) dut_b (
        .clock(clock), .reset(reset), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .stall_i(1'b0)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } sb_t;

    sb_t         sb_q[$];
    int          last_issue = -100;
    logic [31:0] cur_exp = 32'h0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Scoreboard monitor for dut_a: grant rule, response order, data and exact issue cycle.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            check("reset_rvalid", 32'(rvalid_a), 32'h0);
            check("reset_rdata", rdata_a, 32'h0);
            sb_q.delete();
            last_issue = -100;
        end else begin
            int due;
            check("gnt_rule", 32'(gnt_a), 32'(req_a && !stall_a && (sb_q.size() < PND)));
            due = 0;
            if (sb_q.size() != 0) begin
                due = sb_q[0].acc + LAT_A;
                if (last_issue + 1 > due) due = last_issue + 1;
            end
            if (rvalid_a) begin
                if (sb_q.size() == 0) begin
                    check("rvalid_unexpected", 32'(rvalid_a), 32'h0);
                end else begin
                    check("rdata", rdata_a, sb_q[0].data);
                    check("rvalid_cycle", 32'(cyc), 32'(due));
                    void'(sb_q.pop_front());
                    last_issue = cyc;
                end
            end else begin
                check("rdata_idle", rdata_a, 32'h0);
                if ((sb_q.size() != 0) && (cyc >= due)) check("rvalid_missing", 32'(rvalid_a), 32'h1);
            end
            if (req_a && gnt_a) sb_q.push_back('{data: cur_exp, acc: cyc});
        end
    end

    task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] e, output int acc);
        @(posedge clock);
        #1;
        req_a = 1'b1; we = w; addr = a; be = b; wdata = d; cur_exp = e;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (gnt_a) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("grant_timeout", 32'(gnt_a), 32'h1);
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        req_a = 1'b0;
    endtask

    task automatic drain();
        int left;
        left = 50;
        while ((sb_q.size() != 0) && (left > 0)) begin
            @(negedge clock);
            left--;
        end
        if (left == 0) check("drain_timeout", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        int acc;
        logic gb_exp[7];
        logic rb_exp[7];

        vecs[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h20,  4'hF, 32'h11223344, 32'h0};
        vecs[3]  = '{1'b1, 32'h20,  4'h5, 32'hAABBCCDD, 32'h0};
        vecs[4]  = '{1'b0, 32'h20,  4'h0, 32'h0,        32'h11BB33DD};
        vecs[5]  = '{1'b0, 32'h23,  4'h0, 32'h0,        32'h11BB33DD};
        vecs[6]  = '{1'b1, 32'h430, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[7]  = '{1'b0, 32'h30,  4'h0, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{1'b1, 32'h40,  4'hF, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 32'h40,  4'h8, 32'hA5A5A5A5, 32'h0};
        vecs[10] = '{1'b1, 32'h40,  4'h0, 32'hFFFFFFFF, 32'h0};
        vecs[11] = '{1'b0, 32'h40,  4'h0, 32'h0,        32'hA5000000};
        vecs[12] = '{1'b1, 32'h3FC, 4'hF, 32'h0BADF00D, 32'h0};
        vecs[13] = '{1'b0, 32'h7FC, 4'h0, 32'h0,        32'h0BADF00D};
        vecs[14] = '{1'b0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF};
        vecs[15] = '{1'b1, 32'h10,  4'hF, 32'h0,        32'h0};
        vecs[16] = '{1'b0, 32'h10,  4'h0, 32'h0,        32'h0};

        gb_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        rb_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; stall_a = 1'b0;
        we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Table vectors, issued back to back so the credit limit is exercised.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp, acc);
            $display("vec %0d: we=%0b addr=%h be=%h wdata=%h accepted cycle %0d", i,
                     vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, acc);
        end
        idle();
        drain();

        // Single read with latency 3: response exactly three cycles after acceptance.
        drive(1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, acc);
        idle();
        @(negedge clock);
        for (int j = 1; j <= 4; j++) begin
            check($sformatf("lat3_rvalid_k+%0d", j), 32'(rvalid_a), 32'(j == LAT_A));
            if (j < 4) @(negedge clock);
        end
        $display("latency sequence: read accepted cycle %0d", acc);
        drain();

        // Grant inhibit for three cycles, then grant as soon as stall drops.
        @(posedge clock);
        #1;
        stall_a = 1'b1; req_a = 1'b1; we = 1'b0; addr = 32'h30; cur_exp = 32'hCAFEF00D;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            check("stall_gnt", 32'(gnt_a), 32'h0);
            check("stall_rvalid", 32'(rvalid_a), 32'h0);
        end
        @(posedge clock);
        #1 stall_a = 1'b0;
        @(negedge clock);
        check("stall_release_gnt", 32'(gnt_a), 32'h1);
        $display("stall sequence: released at cycle %0d", cyc);
        idle();
        drain();

        // Reset with two reads in flight: their responses must never appear.
        drive(1'b0, 32'h10, 4'h0, 32'h0, 32'h0, acc);
        drive(1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, acc);
        @(posedge clock);
        #1;
        reset = 1'b1; req_a = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            check("post_reset_quiet", 32'(rvalid_a), 32'h0);
        end
        drive(1'b0, 32'h30, 4'h0, 32'h0, 32'hCAFEF00D, acc);
        $display("reset sequence: post-reset read accepted cycle %0d", acc);
        idle();
        drain();

        // Credit exhaustion with RESP_LAT=4 on the second instance.
        @(posedge clock);
        #1;
        req_b = 1'b1; we = 1'b0; addr = 32'h10;
        for (int t = 0; t < 7; t++) begin
            @(negedge clock);
            check($sformatf("credit_gnt_t%0d", t), 32'(gnt_b), 32'(gb_exp[t]));
            check($sformatf("credit_rvalid_t%0d", t), 32'(rvalid_b), 32'(rb_exp[t]));
            $display("credit t%0d: gnt=%0b rvalid=%0b", t, gnt_b, rvalid_b);
        end
        @(posedge clock);
        #1 req_b = 1'b0;
        repeat (10) @(posedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 Parameter ADDR_WORDS, default 256, is the backing memory depth in 32-bit words; it SHALL be a power of two.
REQ-002 Parameter MAX_PND, default 2, is the maximum number of granted transactions awaiting rvalid; legal range 1..4.
REQ-003 Parameter RESP_LAT, default 1, is the minimum number of cycles from grant to rvalid; legal range 1..8.
REQ-004 clock  input  1  clock; all state SHALL be updated on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req_i  input  1  initiator request.
REQ-007 gnt_o  output  1  grant; the request is accepted in any cycle where req_i and gnt_o are both high.
REQ-008 addr_i  input  32  byte address.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 be_i  input  4  byte enables.
REQ-011 wdata_i  input  32  write data.
REQ-012 rvalid_o  output  1  response valid.
REQ-013 rdata_o  output  32  response data.
REQ-014 stall_i  input  1  grant inhibit; lets a formal bench or testbench inject grant back-pressure.

Function
REQ-015 gnt_o SHALL be combinational: req_i & !stall_i & (pnd_cnt < MAX_PND).
REQ-016 When pnd_cnt == MAX_PND, gnt_o SHALL be low, even if a response retires in that cycle (no same-cycle credit).
REQ-017 Word index = addr_i[2 +: log2(ADDR_WORDS)]; addr_i[1:0] and the upper bits SHALL be ignored.
REQ-018 On an accepted write, each byte lane with be_i[n] = 1 SHALL be written at that clock edge; lanes with be_i[n] = 0 keep their value.
REQ-019 On an accepted read, the word SHALL be sampled at acceptance and pushed into the response queue.
REQ-020 Reads SHALL return data that includes all earlier accepted writes, and never includes later ones.
REQ-021 Each accepted write SHALL push a response entry with data 32'h0.
REQ-022 A transaction accepted in cycle k SHALL produce rvalid_o no earlier than cycle k+RESP_LAT.
REQ-023 Responses SHALL be strictly in acceptance order.
REQ-024 At most one rvalid_o SHALL occur per cycle; a head entry whose latency has elapsed SHALL be issued in the first such cycle.
REQ-025 rvalid_o is a single-cycle pulse per entry with no back-pressure; rdata_o SHALL hold the entry's data while rvalid_o = 1, and 0 otherwise.
REQ-026 pnd_cnt update: +1 on accept only, -1 on rvalid only, unchanged on both or neither; it SHALL never exceed MAX_PND or underflow.
REQ-027 Each queue entry SHALL carry an age counter that saturates at RESP_LAT.
REQ-028 The queue pointers SHALL wrap modulo MAX_PND.
REQ-029 rvalid_o SHALL never be asserted when pnd_cnt == 0.

Reset
REQ-030 While reset is high, the following SHALL be held at 0: pnd_cnt, queue pointers, age counters, rvalid_o, rdata_o.
REQ-031 Reset asserted mid-operation SHALL drop all pending responses; no rvalid_o for pre-reset transactions SHALL occur after reset is released.
REQ-032 Memory contents SHALL NOT be reset; memory is written only by accepted writes.

Structure
REQ-033 Package obi_resp_pkg SHALL hold the response entry struct {data[31:0], age} and the parameter legal-range constants.
REQ-034 The response queue SHALL be a sub-module, obi_resp_fifo (depth MAX_PND, push/pop/full/empty, head age visible).
REQ-035 The memory array, grant logic and pnd_cnt SHALL live in obi_mem_responder.

Verification
REQ-036 Write 32'hDEADBEEF to 0x10 with be 4'hF, then read 0x10 -> write rvalid with 0, then read rvalid with 32'hDEADBEEF.
REQ-037 Write 32'h11223344 to 0x20 with be 4'hF, then 32'hAABBCCDD with be 4'b0101 -> a read of 0x20 returns 32'h11BB33DD.
REQ-038 RESP_LAT = 3, single read accepted in cycle 5 -> rvalid_o high in cycle 8 only.
REQ-039 MAX_PND = 2, req_i held high, RESP_LAT = 4 -> two grants, then gnt_o low until the first rvalid; the grant in that rvalid cycle is still low; the next grant is one cycle later.
REQ-040 stall_i high for 3 cycles with req_i high -> no grants, no rvalid; the request is granted in the first cycle after stall_i drops.
REQ-041 Two reads granted, reset pulsed before any rvalid -> rvalid_o stays low for 10 cycles after reset release; the next read's response arrives normally.
